// File: rtl/sspim_pkg.sv
// Shared types and helpers for the single-SPI master transaction controller.
// Holds the controller state enum, the operation encodings and two small
// helpers used when picking transmit bytes and deciding whether MISO is kept.
package sspim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_LOAD     = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_XFER     = 3'd4,
        ST_CS_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WRRD = 2'b10;

    // Only read and write-read keep the received bytes; 11 behaves as a write.
    function automatic logic op_has_rx(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_WRRD);
    endfunction

    // Byte 0 is the most significant byte of the command word.
    function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sspim_clkgen.sv
// SPI mode-0 clock generator.
// Ports:
//   clk, reset_n      : system clock, synchronous active-low reset
//   en                : run the divider; when low, counter and SCK are held at 0
//   cfg_sck_div       : half-period minus one, in clk cycles
//   sck_int           : generated SPI clock (idles low)
//   sck_pe / sck_ne   : one-cycle pulses in the cycle before SCK rises / falls
module sspim_clkgen
#(
    parameter int SCK_DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [SCK_DIV_W-1:0] cfg_sck_div,
    output logic                 sck_int,
    output logic                 sck_pe,
    output logic                 sck_ne
);

    logic [SCK_DIV_W-1:0] r_cnt;
    logic                 r_sck;
    logic                 w_tc;

    assign w_tc    = en && (r_cnt == cfg_sck_div);
    assign sck_int = r_sck;
    assign sck_pe  = w_tc && !r_sck;
    assign sck_ne  = w_tc && r_sck;

    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + SCK_DIV_W'(1);
        end
    end

endmodule

// File: rtl/sspim_ctl.sv
// Single-SPI master transaction controller (mode 0).
// Runs a 1..4 byte command: chip-select setup, byte load/present, continuous
// SCK for all bits, chip-select hold, then a one-cycle done.
// Ports:
//   clk, reset_n                  : system clock, synchronous active-low reset
//   cmd_start                     : start pulse, ignored while busy
//   cfg_op/cfg_byte_cnt/cfg_sck_div/wdata : command, captured on accepted start
//   busy, done, rdata             : status and right-justified received bytes
//   sck_int, sck_pe, cs_int_n     : SPI clock, rising-edge strobe, chip select
//   load_byte, byte_out, shift_out, shift_in, byte_in : shift-register handshake
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | CS high, waiting for cmd_start
// CS_SETUP   | CS low, SCK low for D cycles
// LOAD       | load byte 0 into the shift register
// PRESENT    | put bit 7 of byte 0 on MOSI
// XFER       | SCK running, 16*D cycles per byte, bytes back-to-back
// CS_HOLD    | CS low, SCK low for D cycles
// DONE       | CS high, done pulse
module sspim_ctl
    import sspim_pkg::*;
#(
    parameter int SCK_DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_start,
    input  logic [1:0]           cfg_op,
    input  logic [1:0]           cfg_byte_cnt,
    input  logic [SCK_DIV_W-1:0] cfg_sck_div,
    input  logic [31:0]          wdata,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          rdata,
    output logic                 sck_int,
    output logic                 sck_pe,
    output logic                 cs_int_n,
    output logic                 load_byte,
    output logic [7:0]           byte_out,
    output logic                 shift_out,
    output logic                 shift_in,
    input  logic [7:0]           byte_in
);

    state_t               r_state, w_next;
    logic [1:0]           r_op;
    logic [1:0]           r_nbytes_m1;
    logic [1:0]           r_byte;
    logic [2:0]           r_bit;
    logic [SCK_DIV_W-1:0] r_div;
    logic [SCK_DIV_W-1:0] r_tmr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;

    logic                 w_clk_en;
    logic                 w_sck_ne;
    logic                 w_rx;
    logic                 w_last_byte;
    logic                 w_tmr_done;
    logic                 w_accept;
    logic [1:0]           w_sel;

    assign w_clk_en    = (r_state == ST_XFER);
    assign w_rx        = op_has_rx(r_op);
    assign w_last_byte = (r_byte == r_nbytes_m1);
    assign w_tmr_done  = (r_tmr == '0);
    assign w_accept    = (r_state == ST_IDLE) && cmd_start;
    assign rdata       = r_rdata;

    sspim_clkgen #(
        .SCK_DIV_W (SCK_DIV_W)
    ) u_clkgen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (w_clk_en),
        .cfg_sck_div (r_div),
        .sck_int     (sck_int),
        .sck_pe      (sck_pe),
        .sck_ne      (w_sck_ne)
    );

    // Reads transmit zeros regardless of wdata.
    assign byte_out = (load_byte && (r_op != OP_RD)) ? pick_byte(r_wdata, w_sel) : 8'h00;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        cs_int_n  = 1'b0;
        load_byte = 1'b0;
        shift_out = 1'b0;
        shift_in  = 1'b0;
        w_sel     = r_byte;
        case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                cs_int_n = 1'b1;
                if (cmd_start) begin
                    w_next = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (w_tmr_done) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_byte = 1'b1;
                w_next    = ST_PRESENT;
            end
            ST_PRESENT: begin
                shift_out = 1'b1;
                w_next    = ST_XFER;
            end
            ST_XFER: begin
                shift_in = w_rx;
                if (w_sck_ne) begin
                    if ((r_bit == 3'd7) && w_last_byte) begin
                        w_next = ST_CS_HOLD;
                    end else begin
                        shift_out = 1'b1;
                    end
                    // Load the next byte one falling edge early so its bit 7
                    // can be presented on falling edge 8 without a gap.
                    if ((r_bit == 3'd6) && !w_last_byte) begin
                        load_byte = 1'b1;
                        w_sel     = r_byte + 2'd1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (w_tmr_done) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cs_int_n = 1'b1;
                done     = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_op        <= OP_WR;
            r_nbytes_m1 <= '0;
            r_div       <= '0;
            r_tmr       <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= cfg_op;
                r_nbytes_m1 <= cfg_byte_cnt;
                r_div       <= cfg_sck_div;
                r_tmr       <= cfg_sck_div;
                r_wdata     <= wdata;
                r_rdata     <= '0;
                r_bit       <= '0;
                r_byte      <= '0;
            end
            case (r_state)
                ST_CS_SETUP, ST_CS_HOLD: begin
                    if (!w_tmr_done) begin
                        r_tmr <= r_tmr - SCK_DIV_W'(1);
                    end
                end
                ST_XFER: begin
                    if (w_sck_ne) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_byte <= r_byte + 2'd1;
                            if (w_rx) begin
                                r_rdata <= {r_rdata[23:0], byte_in};
                            end
                            if (w_last_byte) begin
                                r_tmr <= r_div;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sspim_ctl.sv
// Self-checking bench for sspim_ctl: directed and randomized transactions
// against a cycle-budget model of the SPI timing plus a shift-register/slave
// model that rebuilds MOSI at each SCK rise and supplies byte_in.
module tb_sspim_ctl;

    logic        clk;
    logic        reset_n;
    logic        cmd_start;
    logic [1:0]  cfg_op;
    logic [1:0]  cfg_byte_cnt;
    logic [7:0]  cfg_sck_div;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        sck_int;
    logic        sck_pe;
    logic        cs_int_n;
    logic        load_byte;
    logic [7:0]  byte_out;
    logic        shift_out;
    logic        shift_in;
    logic [7:0]  byte_in;

    int n_cmp;
    int n_err;

    // shift-register / slave model state
    logic [7:0]  m_sr;
    logic        m_mosi;
    logic [7:0]  m_rx;
    logic [31:0] m_tx;
    int          pe_cnt;

    sspim_ctl #(.SCK_DIV_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_start    (cmd_start),
        .cfg_op       (cfg_op),
        .cfg_byte_cnt (cfg_byte_cnt),
        .cfg_sck_div  (cfg_sck_div),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .sck_int      (sck_int),
        .sck_pe       (sck_pe),
        .cs_int_n     (cs_int_n),
        .load_byte    (load_byte),
        .byte_out     (byte_out),
        .shift_out    (shift_out),
        .shift_in     (shift_in),
        .byte_in      (byte_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_sr   = 8'h00;
        m_mosi = 1'b0;
        m_rx   = 8'h00;
        m_tx   = 32'h0;
        pe_cnt = 0;
        byte_in = 8'h00;
    endtask

    // Called once per cycle at the falling clk edge with the cycle's outputs.
    task automatic step_model(input logic [31:0] sw);
        logic miso;
        if (sck_pe) begin
            m_tx = {m_tx[30:0], m_mosi};
            miso = (pe_cnt < 32) ? sw[31 - pe_cnt] : 1'b0;
            if (shift_in) m_rx = {m_rx[6:0], miso};
            pe_cnt++;
        end
        if (load_byte) begin
            if (shift_out) m_mosi = m_sr[7];
            m_sr = byte_out;
        end else if (shift_out) begin
            m_mosi = m_sr[7];
            m_sr   = {m_sr[6:0], 1'b0};
        end
        byte_in = m_rx;
    endtask

    task automatic scramble_cfg();
        cmd_start    = ($urandom_range(0, 5) == 0);
        cfg_op       = 2'($urandom);
        cfg_byte_cnt = 2'($urandom);
        cfg_sck_div  = 8'($urandom);
        wdata        = $urandom;
    endtask

    // Must be entered at a falling edge while the DUT is idle; returns at a
    // falling edge in the first IDLE cycle after done.
    task automatic run_txn(input int id, input logic [1:0] op, input logic [1:0] nm1,
                           input logic [7:0] div, input logic [31:0] wd, input logic [31:0] sw);
        int D, N, T;
        int done_cyc, done_cnt, first_pe, last_pe;
        int gap_bad, cs_bad, busy_bad, si_cnt, hi_cnt, ld_cnt;
        logic [31:0] exp_rd, exp_tx, rd_at_done, rd_after;
        logic post_busy, rx_op, fin;
        D = int'(div) + 1;
        N = int'(nm1) + 1;
        T = 2 * D + 3 + 16 * N * D;
        rx_op  = (op == 2'b01) || (op == 2'b10);
        exp_rd = rx_op ? (sw >> (32 - 8 * N)) : 32'h0;
        exp_tx = (op == 2'b01) ? 32'h0 : (wd >> (32 - 8 * N));
        done_cyc = 0; done_cnt = 0; first_pe = 0; last_pe = 0;
        gap_bad = 0; cs_bad = 0; busy_bad = 0; si_cnt = 0; hi_cnt = 0; ld_cnt = 0;
        rd_at_done = 32'hDEAD_BEEF; rd_after = 32'hDEAD_BEEF; post_busy = 1'b1; fin = 1'b0;
        model_clear();

        cmd_start    = 1'b1;
        cfg_op       = op;
        cfg_byte_cnt = nm1;
        cfg_sck_div  = div;
        wdata        = wd;

        for (int cyc = 1; cyc <= T + 20 && !fin; cyc++) begin
            @(negedge clk);
            if (cs_int_n != !(cyc < T)) cs_bad++;
            if (busy != (cyc <= T)) busy_bad++;
            if (shift_in) si_cnt++;
            if (sck_int) hi_cnt++;
            if (load_byte) ld_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc   = cyc;
                    rd_at_done = rdata;
                end
            end
            step_model(sw);
            if (sck_pe) begin
                if (pe_cnt == 1) first_pe = cyc;
                else if (cyc - last_pe != 2 * D) gap_bad++;
                last_pe = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                post_busy = busy;
                rd_after  = rdata;
                cmd_start = 1'b0;
                fin       = 1'b1;
            end else if (done && done_cyc == cyc) begin
                cmd_start = 1'b1;   // must be ignored in the DONE cycle
            end else begin
                scramble_cfg();
            end
        end
        cmd_start = 1'b0;

        chk($sformatf("t%0d_done_cycle", id), 32'(done_cyc), 32'(T));
        chk($sformatf("t%0d_done_count", id), 32'(done_cnt), 32'd1);
        chk($sformatf("t%0d_rdata", id), rd_at_done, exp_rd);
        chk($sformatf("t%0d_rdata_held", id), rd_after, exp_rd);
        chk($sformatf("t%0d_mosi_bits", id), m_tx, exp_tx);
        chk($sformatf("t%0d_sck_rises", id), 32'(pe_cnt), 32'(8 * N));
        chk($sformatf("t%0d_first_rise", id), 32'(first_pe), 32'(2 * D + 2));
        chk($sformatf("t%0d_rise_gaps", id), 32'(gap_bad), 32'd0);
        chk($sformatf("t%0d_shift_in_cycles", id), 32'(si_cnt), rx_op ? 32'(16 * N * D) : 32'd0);
        chk($sformatf("t%0d_sck_high_cycles", id), 32'(hi_cnt), 32'(8 * N * D));
        chk($sformatf("t%0d_loads", id), 32'(ld_cnt), 32'(N));
        chk($sformatf("t%0d_cs_window", id), 32'(cs_bad), 32'd0);
        chk($sformatf("t%0d_busy_window", id), 32'(busy_bad), 32'd0);
        chk($sformatf("t%0d_start_in_done_ignored", id), 32'(post_busy), 32'd0);
    endtask

    task automatic run_reset_test(input logic [7:0] div);
        logic [31:0] sw;
        logic found;
        int idle_done, idle_busy;
        sw    = 32'hC35A_0000 | 32'($urandom_range(0, 16'hFFFF));
        found = 1'b0;
        model_clear();
        cmd_start    = 1'b1;
        cfg_op       = 2'b01;
        cfg_byte_cnt = 2'd3;
        cfg_sck_div  = div;
        wdata        = $urandom;
        for (int cyc = 1; cyc < 5000 && !found; cyc++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            step_model(sw);
            if (pe_cnt == 12) found = 1'b1;   // inside bit 4 of the second byte
        end
        chk("rst_reached_byte2", 32'(found), 32'd1);
        chk("rst_pre_rdata", rdata, 32'h0000_00C3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_ctl_bits", {24'h0, busy, done, cs_int_n, sck_int, sck_pe, load_byte, shift_out, shift_in},
            32'h0000_0020);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_byte_out", 32'(byte_out), 32'h0);
        reset_n   = 1'b1;
        idle_done = 0;
        idle_busy = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) idle_done++;
            if (busy || !cs_int_n) idle_busy++;
        end
        chk("rst_no_done", 32'(idle_done), 32'd0);
        chk("rst_stays_idle", 32'(idle_busy), 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        clk          = 1'b0;
        reset_n      = 1'b0;
        cmd_start    = 1'b0;
        cfg_op       = 2'b00;
        cfg_byte_cnt = 2'd0;
        cfg_sck_div  = 8'd0;
        wdata        = 32'h0;
        model_clear();

        repeat (3) @(negedge clk);
        chk("reset_ctl_bits", {24'h0, busy, done, cs_int_n, sck_int, sck_pe, load_byte, shift_out, shift_in},
            32'h0000_0020);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_byte_out", 32'(byte_out), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(1, 2'b00, 2'd0, 8'd1, 32'hA500_0000 | 32'($urandom_range(0, 24'hFF_FFFF)), $urandom);
        run_txn(2, 2'b10, 2'd3, 8'($urandom_range(0, 3)), 32'h0123_4567, 32'h89AB_CDEF);
        run_txn(3, 2'b01, 2'd1, 8'd0, $urandom, 32'h3CC3_0000 | 32'($urandom_range(0, 16'hFFFF)));
        run_txn(4, 2'b11, 2'($urandom), 8'($urandom_range(0, 3)), $urandom, $urandom);
        for (int i = 0; i < 16; i++) begin
            run_txn(10 + i, 2'($urandom), 2'($urandom), 8'($urandom_range(0, 4)), $urandom, $urandom);
        end
        run_reset_test(8'd2);
        run_txn(40, 2'b10, 2'd3, 8'd0, $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sspim_ctl.md
# sspim_ctl

Transaction controller for the single-SPI master, sitting directly upstream of the SPI shift-register interface. It accepts a 1–4 byte command from the register block and generates the SPI clock, chip-select and per-byte load/shift strobes. It returns the received bytes as a 32-bit word.
- SPI mode 0 only: SCK idles low, MOSI changes on the falling edge, MISO is sampled on the rising edge.

## Interface
Parameters
- `SCK_DIV_W`, default 8: width of the clock-divider configuration.

Ports
- `clk` in 1: system clock.
- `reset_n` in 1: reset; synchronous, active-low.
- `cmd_start` in 1: one-cycle start pulse. Ignored while `busy`.
- `cfg_op` in 2: operation.
  - 00 write; 01 read (transmits 0x00); 10 write-read; 11 treated as write.
- `cfg_byte_cnt` in 2: number of bytes minus 1 (0 → 1 byte, 3 → 4 bytes).
- `cfg_sck_div` in SCK_DIV_W: half-period = D = `cfg_sck_div`+1 clk cycles.
- `wdata` in 32: transmit bytes, sent MSB byte first (`wdata[31:24]`, then `[23:16]`, …).
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse at end of transaction; `rdata` is valid from this cycle.
- `rdata` out 32: received bytes, right-justified (last byte in `[7:0]`). Held until the next start.
- `sck_int` out 1: SPI clock to the interface stage.
- `sck_pe` out 1: one-cycle pulse in the cycle before `sck_int` rises.
- `cs_int_n` out 1: active-low chip select.
- `load_byte` out 1: loads `byte_out` into the shift register.
- `byte_out` out 8: byte to transmit.
- `shift_out` out 1: present the next MOSI bit.
- `shift_in` out 1: enables MISO sampling on `sck_pe`.
- `byte_in` in 8: received shift-register contents.

## Operation
- Configuration (`cfg_*`, `wdata`) is captured on the accepted start. Later changes have no effect until the next transaction.
- FSM states: IDLE → CS_SETUP → LOAD → PRESENT → XFER → CS_HOLD → DONE → IDLE.
- IDLE:
  - `cs_int_n`=1, `sck_int`=0, all strobes 0.
  - `cmd_start` moves to CS_SETUP, drives `cs_int_n` to 0 and `busy` to 1.
- CS_SETUP: D cycles with `cs_int_n` low and SCK low.
- LOAD: one cycle, `load_byte`=1, `byte_out` = byte 0.
- PRESENT: one cycle, `shift_out`=1, which places bit 7 on MOSI.
- XFER:
  - Divider restarts at 0 on entry. `sck_int` toggles every D cycles, giving 8 rising and 8 falling edges per byte.
  - `shift_in` = 1 for ops 01/10 throughout XFER.
  - `shift_out` pulses with falling edges 1–7 of each byte.
  - Falling edge 7, if more bytes remain: `load_byte` pulses in the same cycle as `shift_out`, with `byte_out` = next byte (back-to-back case).
  - Falling edge 8, if more bytes remain: `shift_out` pulses (bit 7 of the next byte) and XFER continues without a gap.
  - Falling edge 8: `rdata <= {rdata[23:0], byte_in}` when `shift_in` is 1.
  - Last byte's falling edge 8 → CS_HOLD.
- CS_HOLD: D cycles with SCK low and CS still low.
- DONE: `cs_int_n`=1, `done`=1 for one cycle. `busy` drops the following cycle.
- `rdata` clears to 0 on an accepted start. It is unchanged for op 00/11.
- Reset: on any clock edge with `reset_n`=0, from any state, the next cycle shows:
  - state IDLE, `busy`=0, `done`=0;
  - `cs_int_n`=1, `sck_int`=0;
  - `sck_pe`, `load_byte`, `shift_out`, `shift_in` = 0;
  - `byte_out`=0, `rdata`=0.
- No partial `done` is issued after a mid-transfer reset.

## Timing
- Start is sampled in cycle 0. `cs_int_n` is low from cycle 1.
- With N bytes:
  - LOAD in cycle D+1;
  - PRESENT in cycle D+2;
  - XFER for 16·N·D cycles;
  - `done` in cycle 2D+3+16·N·D.
- `sck_pe` and the rising toggle of `sck_int` share one clk edge, so MISO is sampled exactly when SCK rises.
- Minimum SCK period is 2 clk cycles (`cfg_sck_div`=0).
- `cmd_start` in the same cycle as DONE is ignored. A new start is accepted from the first IDLE cycle after DONE.

## Structure
- Package `sspim_pkg`:
  - state enum;
  - op encodings (`OP_WR`, `OP_RD`, `OP_WRRD`).
- Sub-module `sspim_clkgen`:
  - inputs: `clk`, `reset_n`, enable, `cfg_sck_div`;
  - outputs: `sck_int`, `sck_pe`, `sck_ne`, each pulse one cycle wide;
  - held in reset state (counter 0, SCK low) when not enabled.
- Bit counter (3 bits) and byte counter (2 bits) live in `sspim_ctl`.

## Test plan
- Write, 1 byte:
  - stimulus: `cfg_sck_div`=1, `wdata`=0xA5xxxxxx, op 00;
  - response: MOSI=10100101 at the 8 rising edges; `shift_in`=0 throughout; `done` at cycle 39; `rdata`=0.
- Write-read, 4 bytes:
  - stimulus: `wdata`=0x0123_4567; slave returns 0x89,0xAB,0xCD,0xEF;
  - response: 32 contiguous SCK periods with no gap; `rdata`=0x89AB_CDEF.
- Read, 2 bytes:
  - stimulus: `cfg_sck_div`=0; slave returns 0x3C,0xC3;
  - response: MOSI all 0; `rdata`=0x0000_3CC3; `done` at cycle 37.
- Start ignored while busy:
  - stimulus: second `cmd_start` mid-XFER;
  - response: exactly one `done`; original data unchanged.
- Reset mid-byte:
  - stimulus: `reset_n` low during bit 4 of byte 2;
  - response: next cycle `cs_int_n`=1, `sck_int`=0, `busy`=0, `rdata`=0; no `done`; new transaction afterwards completes normally.
- Config change during busy:
  - stimulus: modify `cfg_sck_div` and `wdata` mid-transfer;
  - response: SCK period and transmitted bytes stay at the captured values.
